stream_mux_nto1: RTL and testbench
==================================

STREAM_MUX_NTO1 -- requirements
Module: stream_mux_nto1

Interface
REQ-001 Parameter WIDTH, default 32: data width per channel in bits (1..64).
REQ-002 Parameter NUM_IN, default 4: number of input channels (2..16).
REQ-003 Parameter MODE, default 0: 0 = external select, 1 = round-robin arbitration.
REQ-004 Derived SEL_W = max(1, clog2(NUM_IN)), fixed and not overridable.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_data  input  NUM_IN*WIDTH  channel i at bits [i*WIDTH +: WIDTH].
REQ-008 in_valid  input  NUM_IN  channel i offers a word.
REQ-009 in_ready  output  NUM_IN  channel i word accepted this cycle when in_valid[i] & in_ready[i].
REQ-010 sel  input  SEL_W  channel select; used only when MODE=0.
REQ-011 out_data  output  WIDTH  registered selected word.
REQ-012 out_src  output  SEL_W  registered index of the channel that supplied out_data.
REQ-013 out_valid  output  1  out_data/out_src hold a word.
REQ-014 out_ready  input  1  downstream accepts when out_valid & out_ready.

Function
REQ-015 Single-entry output register; free = ~out_valid | out_ready (pass-through on the same-cycle pop).
REQ-016 Grant g computed combinationally each cycle; at most one in_ready bit high; in_ready[g] = free & ~reset, all others 0.
REQ-017 MODE=0: g = sel; sel >= NUM_IN grants nothing (all in_ready 0, no load).
REQ-018 MODE=0: unselected channels never accepted, even if valid.
REQ-019 MODE=1: g = first valid channel searching upward from (rr_ptr+1) mod NUM_IN with wrap-around; none valid -> no grant; sel ignored.
REQ-020 MODE=1: rr_ptr updates to g only on an accepted transfer; otherwise holds.
REQ-021 On accept (in_valid[g] & in_ready[g]): next cycle out_data = in_data[g], out_src = g, out_valid = 1; latency exactly 1 cycle.
REQ-022 Free with no accept: out_valid becomes 0 next cycle; out_data and out_src hold their last values.
REQ-023 Not free (out_valid & ~out_ready): out_data, out_src, out_valid held stable; rr_ptr held; no in_ready asserted.
REQ-024 Simultaneous pop and accept: new word loaded, out_valid stays 1; sustained throughput one word per cycle.
REQ-025 Word is consumed exactly once: no duplication, no drop, under any valid/ready pattern.
REQ-026 in_ready shall not depend on in_valid of the granted channel in MODE=0; in MODE=1 it depends only on the in_valid vector, rr_ptr, out_valid, out_ready.
REQ-027 No combinational path from in_data to out_data; out_* driven only from flops.

Reset
REQ-028 While reset=1 at a rising edge: out_valid=0, out_data=0, out_src=0, rr_ptr=NUM_IN-1 (channel 0 first priority after reset).
REQ-029 During the reset-high cycle all in_ready = 0; no transfer is counted.
REQ-030 Reset mid-operation discards any held output word; first accept after release follows REQ-019 from rr_ptr=NUM_IN-1.

Verification
REQ-031 MODE=0, NUM_IN=4, sel=2, in_valid=4'b0100, in_data[2]=32'hDEADBEEF, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=32'hDEADBEEF, out_src=2.
REQ-032 MODE=1, all four channels valid continuously, out_ready=1 after reset -> out_src sequence 0,1,2,3,0,... one word per cycle.
REQ-033 MODE=1, in_valid=4'b1010, out_ready=1 after reset -> out_src alternates 1,3,1,3; channels 0 and 2 never granted.
REQ-034 out_valid=1, out_ready=0 held 5 cycles with all channels valid -> in_ready=0, out_data/out_src unchanged, rr_ptr unchanged; on out_ready=1 accept resumes from the next channel.
REQ-035 MODE=0, sel=3'd5 with NUM_IN=5... use NUM_IN=4, sel=4 is illegal width; instead NUM_IN=5, sel=3'd6, all valid -> in_ready=0, out_valid falls to 0 after pop.
REQ-036 Reset asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0, out_data=0, out_src=0; first accept after release grants channel 0 in MODE=1.

Source files
------------

// File: rtl/stream_mux_nto1_if.sv
// rtl/stream_mux_nto1_if.sv - handshake bundle between N input streams, select and one output stream
interface stream_mux_nto1_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4
);
    localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN-1:0]       in_ready;
    logic [SEL_W-1:0]        sel;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_src;
    logic                    out_valid;
    logic                    out_ready;

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        input  sel,
        output out_data,
        output out_src,
        output out_valid,
        input  out_ready
    );

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        output sel,
        input  out_data,
        input  out_src,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/stream_mux_nto1.sv
// rtl/stream_mux_nto1.sv - N-to-1 stream multiplexer, external select or round-robin grant
module stream_mux_nto1 #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int MODE   = 0
) (
    input  logic               clk,
    input  logic               reset,
    stream_mux_nto1_if.slave   bus
);
    localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] grant;
    logic             grant_valid;
    logic             free;
    logic             accept;
    logic [WIDTH-1:0] grant_data;

    assign free   = ~bus.out_valid | bus.out_ready;
    assign accept = |(bus.in_valid & bus.in_ready);

    // Round-robin: scan descending so the closest channel after rr_ptr is assigned last and wins.
    always_comb begin
        int idx;
        idx         = 0;
        grant       = '0;
        grant_valid = 1'b0;
        if (MODE == 0) begin
            grant       = bus.sel;
            grant_valid = (32'(bus.sel) < 32'(NUM_IN));
        end else begin
            for (int k = NUM_IN; k >= 1; k--) begin
                idx = (int'(rr_ptr) + k) % NUM_IN;
                if (bus.in_valid[idx]) begin
                    grant       = idx[SEL_W-1:0];
                    grant_valid = 1'b1;
                end
            end
        end
    end

    always_comb begin
        bus.in_ready = '0;
        grant_data   = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (32'(grant) == 32'(i)) begin
                bus.in_ready[i] = grant_valid & free & ~reset;
                grant_data      = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_src   <= '0;
            rr_ptr        <= SEL_W'(NUM_IN - 1);
        end else if (accept) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= grant_data;
            bus.out_src   <= grant;
            if (MODE == 1) begin
                rr_ptr <= grant;
            end
        end else if (free) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_stream_mux_nto1.sv
// tb/tb_stream_mux_nto1.sv - directed checks of select and round-robin muxing
module tb_stream_mux_nto1;
    logic clk;
    logic reset;
    int   pass_count;
    int   check_count;

    stream_mux_nto1_if #(.WIDTH(32), .NUM_IN(4)) if_a ();
    stream_mux_nto1_if #(.WIDTH(32), .NUM_IN(4)) if_b ();
    stream_mux_nto1_if #(.WIDTH(32), .NUM_IN(5)) if_c ();

    stream_mux_nto1 #(.WIDTH(32), .NUM_IN(4), .MODE(0)) dut_a (.clk(clk), .reset(reset), .bus(if_a));
    stream_mux_nto1 #(.WIDTH(32), .NUM_IN(4), .MODE(1)) dut_b (.clk(clk), .reset(reset), .bus(if_b));
    stream_mux_nto1 #(.WIDTH(32), .NUM_IN(5), .MODE(0)) dut_c (.clk(clk), .reset(reset), .bus(if_c));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        if_a.in_data = {32'h44444444, 32'hDEADBEEF, 32'h22222222, 32'h11111111};
        if_b.in_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        if_c.in_data = {32'hC4, 32'hC3, 32'hC2, 32'hC1, 32'hC0};
        if_a.in_valid = '0; if_b.in_valid = '0; if_c.in_valid = '0;
        if_a.sel = '0; if_b.sel = '0; if_c.sel = '0;
        if_a.out_ready = 1'b1; if_b.out_ready = 1'b1; if_c.out_ready = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_all();
        if_a.in_valid = 4'hF; if_b.in_valid = 4'hF; if_c.in_valid = 5'h1F;
        reset = 1'b1;
        #1;
        check_count++; if (if_a.in_ready !== 4'b0) $display("FAIL reset_ready_a got %b want 0000", if_a.in_ready); else pass_count++;
        check_count++; if (if_b.in_ready !== 4'b0) $display("FAIL reset_ready_b got %b want 0000", if_b.in_ready); else pass_count++;
        check_count++; if (if_c.in_ready !== 5'b0) $display("FAIL reset_ready_c got %b want 00000", if_c.in_ready); else pass_count++;
        tick();
        check_count++; if (if_a.out_valid !== 1'b0) $display("FAIL reset_valid_a got %b want 0", if_a.out_valid); else pass_count++;
        check_count++; if (if_b.out_valid !== 1'b0) $display("FAIL reset_valid_b got %b want 0", if_b.out_valid); else pass_count++;
        check_count++; if (if_a.out_data !== 32'h0) $display("FAIL reset_data_a got %h want 0", if_a.out_data); else pass_count++;
        check_count++; if (if_b.out_src !== 2'd0) $display("FAIL reset_src_b got %0d want 0", if_b.out_src); else pass_count++;
        reset = 1'b0;
        idle_all();
    endtask

    task automatic test_select();
        idle_all();
        do_reset();
        if_a.sel = 2'd2;
        if_a.in_valid = 4'b0100;
        #1;
        check_count++; if (if_a.in_ready !== 4'b0100) $display("FAIL sel2_ready got %b want 0100", if_a.in_ready); else pass_count++;
        tick();
        check_count++; if (if_a.out_valid !== 1'b1) $display("FAIL sel2_valid got %b want 1", if_a.out_valid); else pass_count++;
        check_count++; if (if_a.out_data !== 32'hDEADBEEF) $display("FAIL sel2_data got %h want deadbeef", if_a.out_data); else pass_count++;
        check_count++; if (if_a.out_src !== 2'd2) $display("FAIL sel2_src got %0d want 2", if_a.out_src); else pass_count++;
        // selected channel idle while others are valid: nothing loads, last word stays visible
        if_a.sel = 2'd1;
        if_a.in_valid = 4'b1101;
        #1;
        check_count++; if (if_a.in_ready !== 4'b0010) $display("FAIL sel1_ready got %b want 0010", if_a.in_ready); else pass_count++;
        tick();
        check_count++; if (if_a.out_valid !== 1'b0) $display("FAIL sel1_valid got %b want 0", if_a.out_valid); else pass_count++;
        check_count++; if (if_a.out_data !== 32'hDEADBEEF) $display("FAIL sel1_hold_data got %h want deadbeef", if_a.out_data); else pass_count++;
        check_count++; if (if_a.out_src !== 2'd2) $display("FAIL sel1_hold_src got %0d want 2", if_a.out_src); else pass_count++;
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_ready;
        idle_all();
        do_reset();
        if_b.in_valid = 4'hF;
        for (int k = 0; k < 6; k++) begin
            exp_ready = 4'b0001 << (k % 4);
            #1;
            check_count++; if (if_b.in_ready !== exp_ready) $display("FAIL rr_all_ready[%0d] got %b want %b", k, if_b.in_ready, exp_ready); else pass_count++;
            tick();
            check_count++; if (if_b.out_valid !== 1'b1 || if_b.out_src !== 2'(k % 4) || if_b.out_data !== 32'(32'hA0 + (k % 4)))
                $display("FAIL rr_all_out[%0d] got v=%b src=%0d data=%h want v=1 src=%0d data=%h", k, if_b.out_valid, if_b.out_src, if_b.out_data, k % 4, 32'hA0 + (k % 4));
            else pass_count++;
        end
    endtask

    task automatic test_rr_sparse();
        logic [1:0] exp_src;
        idle_all();
        do_reset();
        if_b.in_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            exp_src = (k % 2 == 0) ? 2'd1 : 2'd3;
            #1;
            check_count++; if (if_b.in_ready !== (4'b0001 << exp_src)) $display("FAIL rr_sparse_ready[%0d] got %b want %b", k, if_b.in_ready, 4'b0001 << exp_src); else pass_count++;
            tick();
            check_count++; if (if_b.out_src !== exp_src) $display("FAIL rr_sparse_src[%0d] got %0d want %0d", k, if_b.out_src, exp_src); else pass_count++;
        end
    endtask

    task automatic test_backpressure();
        idle_all();
        do_reset();
        if_b.in_valid = 4'hF;
        #1;
        check_count++; if (if_b.in_ready !== 4'b0001) $display("FAIL bp_first_ready got %b want 0001", if_b.in_ready); else pass_count++;
        tick();
        if_b.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            check_count++; if (if_b.in_ready !== 4'b0) $display("FAIL bp_stall_ready[%0d] got %b want 0000", k, if_b.in_ready); else pass_count++;
            check_count++; if (if_b.out_valid !== 1'b1 || if_b.out_src !== 2'd0 || if_b.out_data !== 32'hA0)
                $display("FAIL bp_stall_hold[%0d] got v=%b src=%0d data=%h want v=1 src=0 data=a0", k, if_b.out_valid, if_b.out_src, if_b.out_data);
            else pass_count++;
            tick();
        end
        if_b.out_ready = 1'b1;
        #1;
        check_count++; if (if_b.in_ready !== 4'b0010) $display("FAIL bp_resume_ready got %b want 0010", if_b.in_ready); else pass_count++;
        tick();
        check_count++; if (if_b.out_src !== 2'd1 || if_b.out_data !== 32'hA1 || if_b.out_valid !== 1'b1)
            $display("FAIL bp_resume_out got v=%b src=%0d data=%h want v=1 src=1 data=a1", if_b.out_valid, if_b.out_src, if_b.out_data);
        else pass_count++;
    endtask

    task automatic test_illegal_sel();
        idle_all();
        do_reset();
        if_c.in_valid = 5'h1F;
        if_c.sel = 3'd0;
        #1;
        check_count++; if (if_c.in_ready !== 5'b00001) $display("FAIL c_sel0_ready got %b want 00001", if_c.in_ready); else pass_count++;
        tick();
        check_count++; if (if_c.out_valid !== 1'b1 || if_c.out_src !== 3'd0) $display("FAIL c_sel0_out got v=%b src=%0d want v=1 src=0", if_c.out_valid, if_c.out_src); else pass_count++;
        if_c.sel = 3'd4;
        #1;
        check_count++; if (if_c.in_ready !== 5'b10000) $display("FAIL c_sel4_ready got %b want 10000", if_c.in_ready); else pass_count++;
        tick();
        check_count++; if (if_c.out_src !== 3'd4 || if_c.out_data !== 32'hC4) $display("FAIL c_sel4_out got src=%0d data=%h want src=4 data=c4", if_c.out_src, if_c.out_data); else pass_count++;
        if_c.sel = 3'd6;
        #1;
        check_count++; if (if_c.in_ready !== 5'b0) $display("FAIL c_sel6_ready got %b want 00000", if_c.in_ready); else pass_count++;
        tick();
        check_count++; if (if_c.out_valid !== 1'b0) $display("FAIL c_sel6_valid got %b want 0", if_c.out_valid); else pass_count++;
        check_count++; if (if_c.out_src !== 3'd4) $display("FAIL c_sel6_src_hold got %0d want 4", if_c.out_src); else pass_count++;
    endtask

    task automatic test_reset_mid();
        idle_all();
        do_reset();
        if_b.in_valid = 4'hF;
        tick();
        tick();
        if_b.out_ready = 1'b0;
        tick();
        check_count++; if (if_b.out_valid !== 1'b1 || if_b.out_src !== 2'd1) $display("FAIL mid_pre got v=%b src=%0d want v=1 src=1", if_b.out_valid, if_b.out_src); else pass_count++;
        reset = 1'b1;
        #1;
        check_count++; if (if_b.in_ready !== 4'b0) $display("FAIL mid_reset_ready got %b want 0000", if_b.in_ready); else pass_count++;
        tick();
        check_count++; if (if_b.out_valid !== 1'b0 || if_b.out_src !== 2'd0 || if_b.out_data !== 32'h0)
            $display("FAIL mid_reset_out got v=%b src=%0d data=%h want v=0 src=0 data=0", if_b.out_valid, if_b.out_src, if_b.out_data);
        else pass_count++;
        reset = 1'b0;
        if_b.out_ready = 1'b1;
        #1;
        check_count++; if (if_b.in_ready !== 4'b0001) $display("FAIL mid_after_ready got %b want 0001", if_b.in_ready); else pass_count++;
        tick();
        check_count++; if (if_b.out_valid !== 1'b1 || if_b.out_src !== 2'd0) $display("FAIL mid_after_out got v=%b src=%0d want v=1 src=0", if_b.out_valid, if_b.out_src); else pass_count++;
    endtask

    initial begin
        pass_count  = 0;
        check_count = 0;
        reset       = 1'b1;
        idle_all();
        #2;
        test_reset();
        test_select();
        test_back_to_back();
        test_rr_sparse();
        test_backpressure();
        test_illegal_sel();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule
